// File: rtl/conv_pkg.sv
// Shared types and default sizing for the audio convolution custom instruction.
package conv_pkg;

    localparam int unsigned TAPS      = 32;
    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned ACC_W     = 40;
    localparam int unsigned IDX_W     = $clog2(TAPS);
    localparam int unsigned DEF_SHIFT = 15;

    typedef enum logic [1:0] {
        OP_PUSH      = 2'd0,
        OP_LOAD_COEF = 2'd1,
        OP_CLEAR     = 2'd2,
        OP_SET_SHIFT = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_ROUND = 2'd2,
        S_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate with clear/enable and a saturating
// arithmetic-shift output stage.
module conv_mac #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ACC_W    = 40
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [SAMPLE_W-1:0] b,
    input  logic [5:0]                 shift,
    output logic signed [SAMPLE_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [2*SAMPLE_W-1:0] prod;
    logic signed [ACC_W-1:0]      acc_q;
    logic signed [ACC_W-1:0]      shifted;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

    assign shifted = acc_q >>> shift;

    always_comb begin
        y = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            y = SAT_MAX[SAMPLE_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y = SAT_MIN[SAMPLE_W-1:0];
        end
    end

endmodule

// File: rtl/conv_sequencer_ci.sv
// Nios II multi-cycle custom instruction: sequences a TAPS-deep FIR over a
// circular sample history using one shared MAC.
module conv_sequencer_ci #(
    parameter int unsigned TAPS      = conv_pkg::TAPS,
    parameter int unsigned SAMPLE_W  = conv_pkg::SAMPLE_W,
    parameter int unsigned ACC_W     = conv_pkg::ACC_W,
    parameter int unsigned DEF_SHIFT = conv_pkg::DEF_SHIFT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);
    import conv_pkg::*;

    localparam int unsigned IDX_W = $clog2(TAPS);

    state_e                      state_q, state_d;
    op_e                         op;
    logic [IDX_W-1:0]            k_q, wp_q, rd_idx, cidx;
    logic [5:0]                  shift_q, shift_new;
    logic [31:0]                 result_q;
    logic signed [SAMPLE_W-1:0]  hist_q [TAPS];
    logic signed [SAMPLE_W-1:0]  coef_q [TAPS];
    logic signed [SAMPLE_W-1:0]  sample, mac_y;
    logic                        accept, mac_clr, mac_en, last_tap;
    logic                        unused_bits;

    assign op        = op_e'(datab[1:0]);
    assign cidx      = datab[8 +: IDX_W];
    assign sample    = dataa[SAMPLE_W-1:0];
    assign rd_idx    = wp_q - k_q;
    assign last_tap  = (k_q == IDX_W'(TAPS - 1));
    assign shift_new = (dataa[5:0] > 6'(ACC_W - 1)) ? 6'(ACC_W - 1) : dataa[5:0];
    assign accept    = clk_en && start && (state_q == S_IDLE);
    assign mac_clr   = accept && (op == OP_PUSH);
    assign mac_en    = clk_en && (state_q == S_MAC);

    assign unused_bits = ^{dataa[31:SAMPLE_W], datab[31:8+IDX_W], datab[7:2]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = (op == OP_PUSH) ? S_MAC : S_ACK;
            S_MAC:   if (last_tap) state_d = S_ROUND;
            S_ROUND: state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The history is a flop array, so the sample written on the accept edge is
    // already visible when tap 0 reads hist[wp] in the first MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            wp_q     <= '0;
            shift_q  <= 6'(DEF_SHIFT);
            result_q <= '0;
            for (int i = 0; i < int'(TAPS); i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else if (clk_en) begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        unique case (op)
                            OP_PUSH: begin
                                hist_q[wp_q] <= sample;
                                k_q          <= '0;
                            end
                            OP_LOAD_COEF: begin
                                coef_q[cidx] <= sample;
                                result_q     <= '0;
                            end
                            OP_CLEAR: begin
                                for (int i = 0; i < int'(TAPS); i++) hist_q[i] <= '0;
                                wp_q     <= '0;
                                result_q <= '0;
                            end
                            OP_SET_SHIFT: begin
                                shift_q  <= shift_new;
                                result_q <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MAC: begin
                    k_q <= k_q + IDX_W'(1);
                    if (last_tap) wp_q <= wp_q + IDX_W'(1);
                end
                S_ROUND: result_q <= {{(32-SAMPLE_W){mac_y[SAMPLE_W-1]}}, mac_y};
                default: ;
            endcase
        end
    end

    conv_mac #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (hist_q[rd_idx]),
        .b     (coef_q[k_q]),
        .shift (shift_q),
        .y     (mac_y)
    );

    assign result = result_q;
    assign done   = (state_q == S_ACK);

endmodule

// File: tb/tb_conv_sequencer_ci.sv
// Directed bench for conv_sequencer_ci with a reference convolution model and
// a result scoreboard.
module tb_conv_sequencer_ci;

    localparam int TAPS     = 32;
    localparam int LAT_PUSH = TAPS + 2;

    logic        clk = 1'b0;
    logic        reset, clk_en, start;
    logic [31:0] dataa, datab, result;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] last_res;

    int m_hist[TAPS];
    int m_coef[TAPS];
    int m_shift, m_wp;

    conv_sequencer_ci dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sext16(input logic [31:0] v);
        logic signed [15:0] s;
        s = v[15:0];
        return int'(s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_hist[i] = 0;
            m_coef[i] = 0;
        end
        m_wp    = 0;
        m_shift = 15;
    endtask

    function automatic logic [31:0] model_push(input logic [31:0] a);
        longint acc, y;
        acc = 0;
        m_hist[m_wp] = sext16(a);
        for (int k = 0; k < TAPS; k++)
            acc += longint'(m_hist[(m_wp - k + TAPS) % TAPS]) * longint'(m_coef[k]);
        m_wp = (m_wp + 1) % TAPS;
        y = acc >>> m_shift;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        return 32'(y);
    endfunction

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input int idx,
                         input bit has_want, input logic [31:0] want, input string tag);
        logic [31:0] exp;
        int          lat;
        bit          got;
        case (op)
            2'd0: exp = model_push(a);
            2'd1: begin m_coef[idx % TAPS] = sext16(a); exp = 0; end
            2'd2: begin for (int i = 0; i < TAPS; i++) m_hist[i] = 0; m_wp = 0; exp = 0; end
            default: begin m_shift = (a[5:0] > 39) ? 39 : int'(a[5:0]); exp = 0; end
        endcase
        if (has_want) exp = want;
        @(negedge clk);
        start = 1'b1;
        dataa = a;
        datab = {16'h0, 8'(idx), 6'h0, op};
        sb.push_back(exp);
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                lat = i;
                break;
            end
        end
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), (op == 2'd0) ? 32'(LAT_PUSH) : 32'd1);
        last_res = sb.pop_front();
        check({tag, "_res"}, result, last_res);
    endtask

    initial begin
        logic [31:0] exp;
        int          lat, bad, holds;
        bit          got;

        model_reset();
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Impulse
        do_op(2'd3, 32'd0, 0, 0, 0, "imp_shift");
        do_op(2'd1, 32'd1, 0, 0, 0, "imp_coef");
        do_op(2'd0, 32'd100, 0, 1, 32'h0000_0064, "imp_push");

        // Delay tap at c[3]
        do_op(2'd2, 32'd0, 0, 0, 0, "dly_clear");
        do_op(2'd3, 32'd0, 0, 0, 0, "dly_shift");
        do_op(2'd1, 32'd0, 0, 0, 0, "dly_c0");
        do_op(2'd1, 32'd1, 3, 0, 0, "dly_c3");
        do_op(2'd0, 32'd5, 0, 1, 32'd0, "dly_p5");
        do_op(2'd0, 32'd6, 0, 1, 32'd0, "dly_p6");
        do_op(2'd0, 32'd7, 0, 1, 32'd0, "dly_p7");
        do_op(2'd0, 32'd8, 0, 1, 32'd5, "dly_p8");

        // Wrap-around; index 63 aliases to c[31]
        do_op(2'd2, 32'd0, 0, 0, 0, "wrap_clear");
        do_op(2'd1, 32'd0, 3, 0, 0, "wrap_c3");
        do_op(2'd1, 32'd1, 63, 0, 0, "wrap_c31");
        for (int n = 1; n <= 40; n++)
            do_op(2'd0, 32'(n), 0, 1, (n >= 32) ? 32'(n - 31) : 32'd0, $sformatf("wrap_p%0d", n));

        // Saturation both ways
        do_op(2'd2, 32'd0, 0, 0, 0, "sat_clear");
        for (int k = 0; k < TAPS; k++) do_op(2'd1, 32'h7FFF, k, 0, 0, "sat_coef");
        do_op(2'd0, 32'h7FFF, 0, 1, 32'h0000_7FFF, "sat_pos");
        do_op(2'd2, 32'd0, 0, 0, 0, "sat_clear2");
        do_op(2'd0, 32'h8001, 0, 1, 32'hFFFF_8000, "sat_neg");

        // Shift clamps to 39: a large negative sum shifts down to -1
        do_op(2'd3, 32'd63, 0, 0, 0, "clamp_shift");
        do_op(2'd0, 32'h8001, 0, 1, 32'hFFFF_FFFF, "clamp_push");

        // Random coefficients and samples against the model
        do_op(2'd2, 32'd0, 0, 0, 0, "rnd_clear");
        do_op(2'd3, 32'd12, 0, 0, 0, "rnd_shift");
        for (int k = 0; k < TAPS; k++) do_op(2'd1, 32'($urandom_range(0, 65535)), k, 0, 0, "rnd_coef");
        for (int n = 0; n < 12; n++)
            do_op(2'd0, 32'($urandom_range(0, 65535)), 0, 0, 0, $sformatf("rnd_p%0d", n));

        // A done held by clk_en low persists, then clears on the next enabled edge
        clk_en = 1'b0;
        holds = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) holds++;
        end
        check("hold_done", 32'(holds), 32'd3);
        clk_en = 1'b1;
        @(negedge clk);
        check("hold_release", 32'(done), 32'd0);

        // Stall for 5 cycles mid-MAC with start pulsed while busy
        exp = model_push(32'h1234);
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b1;
        dataa = 32'h1234;
        datab = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        got = 0;
        lat = 0;
        bad = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                lat = i;
                break;
            end
            if (result !== last_res) bad++;
            if (i == 11) clk_en = 1'b0;
            if (i == 13) begin
                start = 1'b1;
                datab = 32'd2;
            end
            if (i == 16) clk_en = 1'b1;
            if (i == 19) start = 1'b0;
        end
        check("stall_done", 32'(got), 32'd1);
        check("stall_lat", 32'(lat), 32'(LAT_PUSH + 5));
        check("stall_hold_res", 32'(bad), 32'd0);
        last_res = sb.pop_front();
        check("stall_res", result, last_res);
        holds = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) holds++;
        end
        check("stall_no_extra", 32'(holds), 32'd0);
        check("stall_res_kept", result, last_res);
        do_op(2'd0, 32'h0F00, 0, 0, 0, "stall_after");

        // Reset at k=10 aborts the push and wipes all state
        @(negedge clk);
        start = 1'b1;
        dataa = 32'd9;
        datab = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_done2", 32'(done), 32'd0);
        do_op(2'd1, 32'd1, 0, 0, 0, "rst_c0");
        do_op(2'd3, 32'd0, 0, 0, 0, "rst_shift");
        do_op(2'd0, 32'd7, 0, 1, 32'd7, "rst_push");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
